// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a 2**ADDR_WIDTH-entry register file into a circular FIFO.
// Data stays in the register file; this block only steers write enable and addresses.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_unf;

    logic [CW-1:0]         w_count_nxt;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_ovf_nxt;
    logic                  w_unf_nxt;

    // A push into a full FIFO is allowed only when a pop frees the head slot in the same cycle.
    always_comb begin
        w_push_ok   = wr & (~r_full | rd);
        w_pop_ok    = rd & ~r_empty;
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        // A fresh error in the clearing cycle keeps the flag set.
        w_ovf_nxt = (r_ovf & ~clr_err) | (wr & r_full & ~rd);
        w_unf_nxt = (r_unf & ~clr_err) | (rd & r_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + ADDR_WIDTH'(w_push_ok);
            r_rptr  <= r_rptr + ADDR_WIDTH'(w_pop_ok);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= AF_C);
            r_ae    <= (w_count_nxt <= AE_C);
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign w_en          = w_push_ok & ~rst;
    assign write_address = r_wptr;
    assign read_address  = r_rptr;
    assign full          = r_full;
    assign empty         = r_empty;
    assign almost_full   = r_af;
    assign almost_empty  = r_ae;
    assign count         = r_count;
    assign overflow      = r_ovf;
    assign underflow     = r_unf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a queue-based FIFO model is compared against the controller driving a
// small register file, with directed scenarios followed by random traffic.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic       clr_err;
    logic       w_en;
    logic [2:0] write_address;
    logic [2:0] read_address;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] wdata;
    logic [7:0] mem [8];
    logic [7:0] read_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q [$];
    int         m_wp;
    int         m_rp;
    bit         m_ovf;
    bit         m_unf;

    fifo_ctrl #(
        .ADDR_WIDTH(3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .w_en         (w_en),
        .write_address(write_address),
        .read_address (read_address),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with a combinational read port.
    always @(posedge clk) begin
        if (w_en) mem[write_address] <= wdata;
    end
    assign read_data = mem[read_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wp  = 0;
        m_rp  = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 8));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("write_address", 32'(write_address), 32'(m_wp));
        chk("read_address", 32'(read_address), 32'(m_rp));
    endtask

    // Apply one cycle of requests starting just after a rising edge.
    task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit push_ok;
        bit pop_ok;
        bit was_full;
        bit was_empty;
        wr      = w;
        rd      = r;
        clr_err = c;
        wdata   = d;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        push_ok   = w && (!was_full || r);
        pop_ok    = r && !was_empty;
        @(negedge clk);
        chk("w_en", 32'(w_en), 32'(push_ok));
        if (!was_empty) chk("read_data", 32'(read_data), 32'(q[0]));
        @(posedge clk);
        if (pop_ok) begin
            void'(q.pop_front());
            m_rp = (m_rp + 1) % 8;
        end
        if (push_ok) begin
            q.push_back(d);
            m_wp = (m_wp + 1) % 8;
        end
        m_ovf = (c ? 1'b0 : m_ovf) | (w && was_full && !r);
        m_unf = (c ? 1'b0 : m_unf) | (r && was_empty);
        #1;
        check_state();
    endtask

    initial begin
        rst     = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        wdata   = 8'h00;
        model_reset();
        #12;
        check_state();
        chk("w_en_reset", 32'(w_en), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill: 0x10..0x17
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        // Overflow on full, then clear it
        step(1'b1, 1'b0, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        // Simultaneous push/pop while full
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("slot0", 32'(mem[0]), 32'(8'hAA));
        // Drain all eight, pointer wraps
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        // Underflow on empty, then push+pop on empty
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Bring count to 5, then reset asynchronously mid-cycle during a push
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        wr    = 1'b1;
        rd    = 1'b0;
        wdata = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state();
        chk("w_en_async_rst", 32'(w_en), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        @(posedge clk);
        #1;
        check_state();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 100) < 55), 1'(($urandom % 100) < 45),
                 1'(($urandom % 8) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
